// File: rtl/sid_i2s_tx_if.sv
// rtl/sid_i2s_tx_if.sv - mono sample stream from the SID mixer into the I2S serializer
interface sid_i2s_tx_if;
    logic [15:0] SAMPLE;
    logic        SAMPLE_VALID;

    modport master (output SAMPLE, output SAMPLE_VALID);
    modport slave  (input  SAMPLE, input  SAMPLE_VALID);
endinterface

// File: rtl/sid_i2s_tx.sv
// rtl/sid_i2s_tx.sv - I2S stereo serializer duplicating the mono SID sample into both slots
module sid_i2s_tx #(
    parameter int BCLK_DIV = 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    sid_i2s_tx_if.slave   smp,
    input  logic          CLR_FLAGS,
    output logic          BCLK,
    output logic          LRCLK,
    output logic          SDATA,
    output logic          FRAME_STB,
    output logic          OVERRUN,
    output logic          UNDERRUN
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    logic [DW-1:0] div_cnt;
    logic [4:0]    slot;
    logic [15:0]   hold;
    logic [31:0]   frame;
    logic          fresh;

    logic          div_tc;
    logic          fall;
    logic          load;
    logic          capture;
    logic [4:0]    slot_nxt;

    always_comb begin
        div_tc   = (div_cnt == DIV_LAST);
        fall     = div_tc & BCLK;
        load     = fall & (slot == 5'd31);
        capture  = smp.SAMPLE_VALID;
        slot_nxt = slot + 5'd1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            div_cnt   <= '0;
            slot      <= 5'd31;
            hold      <= '0;
            frame     <= '0;
            fresh     <= 1'b0;
            BCLK      <= 1'b0;
            LRCLK     <= 1'b0;
            SDATA     <= 1'b0;
            FRAME_STB <= 1'b0;
            OVERRUN   <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else begin
            FRAME_STB <= load;

            if (div_tc) begin
                div_cnt <= '0;
                BCLK    <= ~BCLK;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
            end

            // Outputs change only on BCLK falls so the codec samples them on the rise
            if (fall) begin
                slot  <= slot_nxt;
                LRCLK <= (slot_nxt >= 5'd15) && (slot_nxt <= 5'd30);
                if (load) begin
                    frame <= {hold, hold};
                    SDATA <= hold[15];
                end else begin
                    SDATA <= frame[5'd31 - slot_nxt];
                end
            end

            // A capture on the load cycle feeds the next frame, so it stays fresh
            if (capture) begin
                hold  <= smp.SAMPLE;
                fresh <= 1'b1;
            end else if (load) begin
                fresh <= 1'b0;
            end

            OVERRUN  <= (capture & fresh & ~load) | (OVERRUN & ~CLR_FLAGS);
            UNDERRUN <= (load & ~fresh) | (UNDERRUN & ~CLR_FLAGS);
        end
    end
endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb/tb_sid_i2s_tx.sv - scoreboard bench for sid_i2s_tx with BCLK_DIV=2
module tb_sid_i2s_tx;
    logic CLK = 1'b0;
    logic RSTn;
    logic CLR_FLAGS;
    logic BCLK, LRCLK, SDATA, FRAME_STB, OVERRUN, UNDERRUN;

    sid_i2s_tx_if smp ();

    sid_i2s_tx #(.BCLK_DIV(2)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .smp       (smp.slave),
        .CLR_FLAGS (CLR_FLAGS),
        .BCLK      (BCLK),
        .LRCLK     (LRCLK),
        .SDATA     (SDATA),
        .FRAME_STB (FRAME_STB),
        .OVERRUN   (OVERRUN),
        .UNDERRUN  (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: deserialize each frame on BCLK rises, compare with the scoreboard
    logic        mon_active = 1'b0;
    logic        bclk_prev  = 1'b0;
    int          mon_bits   = 0;
    logic [31:0] mon_data   = '0;
    logic [31:0] mon_lr     = '0;

    always @(negedge CLK) begin
        logic [15:0] e;
        if (!RSTn) begin
            mon_active = 1'b0;
            bclk_prev  = 1'b0;
        end else begin
            if (FRAME_STB) begin
                mon_active = 1'b1;
                mon_bits   = 0;
            end
            if (mon_active && BCLK && !bclk_prev) begin
                mon_data = {mon_data[30:0], SDATA};
                mon_lr   = {mon_lr[30:0], LRCLK};
                mon_bits++;
                if (mon_bits == 32) begin
                    mon_active = 1'b0;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("left_word",  {16'h0, mon_data[31:16]}, {16'h0, e});
                        check("right_word", {16'h0, mon_data[15:0]},  {16'h0, e});
                        check("lrclk_slots", mon_lr, 32'h0001_FFFE);
                    end
                end
            end
            bclk_prev = BCLK;
        end
    end

    task automatic wait_frame();
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (FRAME_STB) break;
        end
        check("frame_stb_wait", {31'h0, FRAME_STB}, 32'h1);
    endtask

    task automatic pulse_sample(input logic [15:0] v);
        smp.SAMPLE       = v;
        smp.SAMPLE_VALID = 1'b1;
        @(negedge CLK);
        smp.SAMPLE_VALID = 1'b0;
    endtask

    task automatic pulse_clr();
        CLR_FLAGS = 1'b1;
        @(negedge CLK);
        CLR_FLAGS = 1'b0;
    endtask

    // Release reset between edges and check the first six cycles
    task automatic reset_seq();
        logic [5:0] bclk_tab;
        logic [5:0] fs_tab;
        logic [5:0] ur_tab;
        bclk_tab = 6'b100110;
        fs_tab   = 6'b001000;
        ur_tab   = 6'b111000;
        RSTn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            check("rst_bclk",  {31'h0, BCLK},      {31'h0, bclk_tab[c]});
            check("rst_stb",   {31'h0, FRAME_STB}, {31'h0, fs_tab[c]});
            check("rst_ur",    {31'h0, UNDERRUN},  {31'h0, ur_tab[c]});
            check("rst_misc",  {29'h0, LRCLK, SDATA, OVERRUN}, 32'h0);
        end
    endtask

    initial begin
        RSTn             = 1'b0;
        CLR_FLAGS        = 1'b0;
        smp.SAMPLE       = '0;
        smp.SAMPLE_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {26'h0, BCLK, LRCLK, SDATA, FRAME_STB, OVERRUN, UNDERRUN}, 32'h0);
        reset_seq();

        pulse_sample(16'hA5C3);
        wait_frame();
        exp_q.push_back(16'hA5C3);
        check("ser_ur_kept", {31'h0, UNDERRUN}, 32'h1);

        pulse_sample(16'h8000);
        pulse_clr();
        wait_frame();
        exp_q.push_back(16'h8000);
        pulse_sample(16'h7FFF);
        wait_frame();
        exp_q.push_back(16'h7FFF);
        pulse_sample(16'h0000);
        wait_frame();
        exp_q.push_back(16'h0000);
        check("steady_ovr", {31'h0, OVERRUN}, 32'h0);
        check("steady_ur",  {31'h0, UNDERRUN}, 32'h0);

        pulse_sample(16'h1111);
        repeat (5) @(negedge CLK);
        pulse_sample(16'h2222);
        check("overrun_set", {31'h0, OVERRUN}, 32'h1);
        wait_frame();
        exp_q.push_back(16'h2222);
        check("overrun_no_ur", {31'h0, UNDERRUN}, 32'h0);

        // 4444 fresh, then 3333 lands exactly on the next load edge
        pulse_sample(16'h4444);
        pulse_clr();
        repeat (125) @(negedge CLK);
        pulse_sample(16'h3333);
        check("coinc_stb", {31'h0, FRAME_STB}, 32'h1);
        exp_q.push_back(16'h4444);
        wait_frame();
        exp_q.push_back(16'h3333);
        check("coinc_ovr", {31'h0, OVERRUN}, 32'h0);
        check("coinc_ur",  {31'h0, UNDERRUN}, 32'h0);

        repeat (127) @(negedge CLK);
        CLR_FLAGS = 1'b1;
        @(negedge CLK);
        CLR_FLAGS = 1'b0;
        check("clr_ur_stb", {31'h0, FRAME_STB}, 32'h1);
        check("clr_ur_wins", {31'h0, UNDERRUN}, 32'h1);

        repeat (80) @(negedge CLK);
        check("slot20_lrclk", {31'h0, LRCLK}, 32'h1);
        RSTn = 1'b0;
        #1;
        check("async_rst", {26'h0, BCLK, LRCLK, SDATA, FRAME_STB, OVERRUN, UNDERRUN}, 32'h0);
        repeat (2) @(negedge CLK);
        reset_seq();

        check("queue_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
